if_queue: RTL

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/if_queue_pkg.sv | 12 +
 rtl/if_queue.sv | 72 +++++++
 2 files changed

// File: rtl/if_queue_pkg.sv
// Shared core definitions used by the fetch/decode instruction queue.
package if_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] CORE_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

endpackage

// File: rtl/if_queue.sv
// Fetch-to-decode instruction queue, DEPTH entries; one cycle from push to head, no bypass.
// Backpressure: stall to fetch while full; head held until decode raises id_ready; flush empties.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = CORE_NOP_INST
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  input  logic            j_flush,
  input  logic            b_flush,
  output logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  input  logic            id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          flush;
  logic          push;
  logic          pop;

  assign flush    = j_flush | b_flush;
  assign stall    = (count == CW'(DEPTH));
  assign id_valid = (count != '0);
  // Push is blocked whenever full, even if a pop frees a slot this same cycle.
  assign push     = !flush && !stall;
  assign pop      = id_valid && id_ready && !flush;

  assign head    = mem[rd_ptr];
  assign id_pc   = id_valid ? head.pc   : '0;
  assign id_inst = id_valid ? head.inst : NOP_INST;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
